// File: rtl/ipv4_rx_filter.sv
// IPv4 receive filter: validates MAC/EtherType/IPv4 header and forwards the IP payload.
// All outputs registered (1-cycle latency); no backpressure, rejected datagrams pulse drop_o.
module ipv4_rx_filter #(
  parameter int NUM_IP    = 2,
  parameter bit DROP_FRAG = 1'b1,
  parameter bit BCAST_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [47:0]           dev_mac_addr_i,
  input  logic [32*NUM_IP-1:0]  dev_ip_addr_i,
  input  logic                  rcv_op_i,
  input  logic                  rcv_op_st_i,
  input  logic                  rcv_op_end_i,
  input  logic [31:0]           rcv_data_i,
  input  logic [47:0]           dest_addr_i,
  input  logic [15:0]           prot_type_i,
  output logic                  upper_op_st,
  output logic                  upper_op,
  output logic                  upper_op_end,
  output logic [31:0]           upper_data,
  output logic [3:0]            upper_be,
  output logic [15:0]           upper_data_len,
  output logic [7:0]            prot_type_o,
  output logic [31:0]           source_addr_o,
  output logic [31:0]           dest_addr_o,
  output logic [15:0]           pseudo_crc_sum_o,
  output logic                  drop_o,
  output logic [2:0]            drop_cause_o
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

  state_t      state;
  logic [3:0]  idx, ihl;
  logic [15:0] tot_len, rem, csum;
  logic        mf, first;
  logic [12:0] frag_off;
  logic [7:0]  proto;
  logic [31:0] src_ip, dst_ip;

  function automatic logic [15:0] fold(input logic [19:0] s);
    logic [16:0] t;
    t = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  function automatic logic [3:0] tail_be(input logic [1:0] r);
    case (r)
      2'd1:    return 4'b1000;
      2'd2:    return 4'b1100;
      2'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  logic        start, last_hdr, ip_hit;
  logic [15:0] csum_nxt, hdr_bytes, pay_len, psum;
  logic [31:0] dst_cur;
  logic [2:0]  st_cause, hdr_cause;

  assign start     = rcv_op_i & rcv_op_st_i;
  assign csum_nxt  = fold({4'd0, start ? 16'd0 : csum} + {4'd0, rcv_data_i[31:16]}
                          + {4'd0, rcv_data_i[15:0]});
  assign last_hdr  = (idx == ihl - 4'd1);
  // IHL=5 decides on the destination word itself, before it is registered
  assign dst_cur   = (idx == 4'd4) ? rcv_data_i : dst_ip;
  assign hdr_bytes = {10'd0, ihl, 2'b00};
  assign pay_len   = tot_len - hdr_bytes;
  assign psum      = fold({4'd0, src_ip[31:16]} + {4'd0, src_ip[15:0]}
                          + {4'd0, dst_cur[31:16]} + {4'd0, dst_cur[15:0]}
                          + {12'd0, proto} + {4'd0, pay_len});

  always_comb begin
    st_cause = 3'd0;
    if (!(dest_addr_i == dev_mac_addr_i || (BCAST_EN && (&dest_addr_i))))
      st_cause = 3'd1;
    else if (prot_type_i != 16'h0800)
      st_cause = 3'd2;
    else if (rcv_data_i[31:28] != 4'd4 || rcv_data_i[27:24] < 4'd5)
      st_cause = 3'd3;
  end

  always_comb begin
    ip_hit = BCAST_EN && (dst_cur == 32'hFFFF_FFFF);
    for (int k = 0; k < NUM_IP; k++)
      if (dst_cur == dev_ip_addr_i[32*k +: 32]) ip_hit = 1'b1;
    hdr_cause = 3'd0;
    if (csum_nxt != 16'hFFFF)                          hdr_cause = 3'd4;
    else if (!ip_hit)                                  hdr_cause = 3'd5;
    else if (DROP_FRAG && (mf || frag_off != 13'd0))   hdr_cause = 3'd6;
    else if (tot_len < hdr_bytes)                      hdr_cause = 3'd7;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;  idx <= '0;  ihl <= '0;  tot_len <= '0;  rem <= '0;  csum <= '0;
      mf <= 1'b0;  first <= 1'b0;  frag_off <= '0;  proto <= '0;  src_ip <= '0;  dst_ip <= '0;
      upper_op_st <= 1'b0;  upper_op <= 1'b0;  upper_op_end <= 1'b0;
      upper_data <= '0;  upper_be <= '0;  upper_data_len <= '0;  prot_type_o <= '0;
      source_addr_o <= '0;  dest_addr_o <= '0;  pseudo_crc_sum_o <= '0;
      drop_o <= 1'b0;  drop_cause_o <= '0;
    end else begin
      upper_op_st  <= 1'b0;
      upper_op     <= 1'b0;
      upper_op_end <= 1'b0;
      upper_data   <= '0;
      upper_be     <= '0;
      drop_o       <= 1'b0;
      if (start) begin
        // A new start beat aborts any datagram still in flight
        if (state == HDR || state == PAYLOAD) begin
          drop_o <= 1'b1;  drop_cause_o <= 3'd7;
        end
        idx     <= 4'd1;
        ihl     <= rcv_data_i[27:24];
        tot_len <= rcv_data_i[15:0];
        csum    <= csum_nxt;
        if (st_cause != 3'd0) begin
          drop_o <= 1'b1;  drop_cause_o <= st_cause;
          state  <= rcv_op_end_i ? IDLE : DROP;
        end else if (rcv_op_end_i) begin
          drop_o <= 1'b1;  drop_cause_o <= 3'd7;  state <= IDLE;
        end else begin
          state <= HDR;
        end
      end else begin
        case (state)
          HDR: if (rcv_op_i) begin
            idx  <= idx + 4'd1;
            csum <= csum_nxt;
            case (idx)
              4'd1: begin mf <= rcv_data_i[13];  frag_off <= rcv_data_i[12:0]; end
              4'd2: proto  <= rcv_data_i[23:16];
              4'd3: src_ip <= rcv_data_i;
              4'd4: dst_ip <= rcv_data_i;
              default: ;
            endcase
            if (last_hdr) begin
              if (hdr_cause != 3'd0) begin
                drop_o <= 1'b1;  drop_cause_o <= hdr_cause;
                state  <= rcv_op_end_i ? IDLE : DROP;
              end else begin
                upper_data_len   <= pay_len;
                prot_type_o      <= proto;
                source_addr_o    <= src_ip;
                dest_addr_o      <= dst_cur;
                pseudo_crc_sum_o <= psum;
                rem   <= pay_len;
                first <= 1'b1;
                if (rcv_op_end_i) begin
                  state <= IDLE;
                  if (pay_len != 16'd0) begin drop_o <= 1'b1;  drop_cause_o <= 3'd7; end
                end else begin
                  state <= (pay_len == 16'd0) ? DROP : PAYLOAD;
                end
              end
            end else if (rcv_op_end_i) begin
              drop_o <= 1'b1;  drop_cause_o <= 3'd7;  state <= IDLE;
            end
          end
          PAYLOAD: if (rcv_op_i) begin
            upper_op    <= 1'b1;
            upper_data  <= rcv_data_i;
            upper_op_st <= first;
            first       <= 1'b0;
            if (rem <= 16'd4) begin
              upper_op_end <= 1'b1;
              upper_be     <= tail_be(rem[1:0]);
              // trailing Ethernet padding is swallowed silently in DROP
              state        <= rcv_op_end_i ? IDLE : DROP;
            end else begin
              upper_be <= 4'b1111;
              rem      <= rem - 16'd4;
              if (rcv_op_end_i) begin
                upper_op_end <= 1'b1;
                drop_o <= 1'b1;  drop_cause_o <= 3'd7;  state <= IDLE;
              end
            end
          end
          DROP: if (rcv_op_i && rcv_op_end_i) state <= IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ipv4_rx_filter.sv
// Directed-vector bench for ipv4_rx_filter: a frame-level model predicts payload beats,
// drops and header metadata; literal expectations pin the key scenarios.
module tb_ipv4_rx_filter;
  localparam logic [47:0] DEV_MAC = 48'h0200_00AA_BBCC;
  localparam logic [31:0] IP0 = 32'hC0A8_010A;
  localparam logic [31:0] IP1 = 32'hC0A8_010B;

  logic        clk = 1'b0;
  logic        rst;
  logic        rcv_op_i, rcv_op_st_i, rcv_op_end_i;
  logic [31:0] rcv_data_i;
  logic [47:0] dest_addr_i;
  logic [15:0] prot_type_i;
  logic        upper_op_st, upper_op, upper_op_end, drop_o;
  logic [31:0] upper_data, source_addr_o, dest_addr_o;
  logic [3:0]  upper_be;
  logic [15:0] upper_data_len, pseudo_crc_sum_o;
  logic [7:0]  prot_type_o;
  logic [2:0]  drop_cause_o;

  always #5 clk = ~clk;

  ipv4_rx_filter dut (
    .clk(clk), .rst(rst), .dev_mac_addr_i(DEV_MAC), .dev_ip_addr_i({IP1, IP0}),
    .rcv_op_i(rcv_op_i), .rcv_op_st_i(rcv_op_st_i), .rcv_op_end_i(rcv_op_end_i),
    .rcv_data_i(rcv_data_i), .dest_addr_i(dest_addr_i), .prot_type_i(prot_type_i),
    .upper_op_st(upper_op_st), .upper_op(upper_op), .upper_op_end(upper_op_end),
    .upper_data(upper_data), .upper_be(upper_be), .upper_data_len(upper_data_len),
    .prot_type_o(prot_type_o), .source_addr_o(source_addr_o), .dest_addr_o(dest_addr_o),
    .pseudo_crc_sum_o(pseudo_crc_sum_o), .drop_o(drop_o), .drop_cause_o(drop_cause_o)
  );

  typedef struct { logic st; logic en; logic [3:0] be; logic [31:0] d; } beat_t;

  beat_t       exp_beats[$];
  int          exp_drops[$];
  logic [15:0] exp_len, exp_psum;
  logic [7:0]  exp_proto;
  logic [31:0] exp_src, exp_dst;

  int checks = 0, errors = 0, cyc = 0;
  bit cmp_en = 1'b0;
  logic [31:0] fr [0:15];
  int w_cyc [0:15];
  int nbeats, drop_cyc, drop_cause, st_cyc, end_cyc;
  logic [31:0] first_d;
  logic [3:0]  last_be;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic int fold16(input int s);
    int t = s;
    while (t > 32'h0000_FFFF) t = (t & 32'h0000_FFFF) + (t >>> 16);
    return t;
  endfunction

  task automatic build(input int ihl, input int tot, input bit mf, input int off,
                       input logic [31:0] dst, input bit flip);
    int s = 0;
    for (int i = 0; i < 16; i++) fr[i] = 32'hC0DE_0000 + 32'(i);
    fr[0] = {4'h4, 4'(ihl), 8'h00, 16'(tot)};
    fr[1] = {16'h1234, 2'b00, mf, 13'(off)};
    fr[2] = {8'h40, 8'h11, 16'h0000};
    fr[3] = 32'h0A00_0001;
    fr[4] = dst;
    for (int i = 5; i < ihl; i++) fr[i] = 32'h0F0F_0000 + 32'(i);
    for (int i = 0; i < ihl; i++) begin
      s += int'(fr[i][31:16]);
      s += int'(fr[i][15:0]);
    end
    fr[2][15:0] = ~16'(fold16(s));
    if (flip) fr[3][0] = ~fr[3][0];
  endtask

  // Frame-level reference: what the filter must do with the whole datagram fr[0..n-1]
  task automatic model(input logic [47:0] mac, input logic [15:0] et, input int n);
    int ihl, tot, len, nb, avail, s, bytes;
    logic [31:0] dst;
    beat_t b;
    ihl = int'(fr[0][27:24]);
    tot = int'(fr[0][15:0]);
    dst = fr[4];
    if (mac != DEV_MAC && mac != 48'hFFFF_FFFF_FFFF) begin exp_drops.push_back(1); return; end
    if (et != 16'h0800) begin exp_drops.push_back(2); return; end
    if (fr[0][31:28] != 4'd4 || ihl < 5) begin exp_drops.push_back(3); return; end
    if (n < ihl) begin exp_drops.push_back(7); return; end
    s = 0;
    for (int i = 0; i < ihl; i++) s += int'(fr[i][31:16]) + int'(fr[i][15:0]);
    if (fold16(s) != 32'h0000_FFFF) begin exp_drops.push_back(4); return; end
    if (dst != IP0 && dst != IP1 && dst != 32'hFFFF_FFFF) begin exp_drops.push_back(5); return; end
    if (fr[1][13] || fr[1][12:0] != 13'd0) begin exp_drops.push_back(6); return; end
    if (tot < 4 * ihl) begin exp_drops.push_back(7); return; end
    len       = tot - 4 * ihl;
    exp_len   = 16'(len);
    exp_proto = fr[2][23:16];
    exp_src   = fr[3];
    exp_dst   = dst;
    exp_psum  = 16'(fold16(int'(fr[3][31:16]) + int'(fr[3][15:0]) + int'(dst[31:16])
                           + int'(dst[15:0]) + int'(fr[2][23:16]) + len));
    if (len == 0) return;
    nb = (len + 3) / 4;
    avail = n - ihl;
    if (avail == 0) begin exp_drops.push_back(7); return; end
    for (int k = 0; k < nb && k < avail; k++) begin
      bytes = (k == nb - 1) ? len - 4 * k : 4;
      b.st = (k == 0);
      b.en = (k == nb - 1) || (k == avail - 1);
      b.be = 4'((15 << (4 - bytes)) & 15);
      b.d  = fr[ihl + k];
      exp_beats.push_back(b);
    end
    if (avail < nb) exp_drops.push_back(7);
  endtask

  task automatic compare();
    beat_t b;
    int c;
    cyc++;
    if (!cmp_en) return;
    if (upper_op === 1'b1) begin
      nbeats++;
      if (upper_op_st === 1'b1) begin
        st_cyc = cyc;
        first_d = upper_data;
        chk("meta_len", 64'(upper_data_len), 64'(exp_len));
        chk("meta_proto", 64'(prot_type_o), 64'(exp_proto));
        chk("meta_src", 64'(source_addr_o), 64'(exp_src));
        chk("meta_dst", 64'(dest_addr_o), 64'(exp_dst));
        chk("meta_psum", 64'(pseudo_crc_sum_o), 64'(exp_psum));
      end
      if (upper_op_end === 1'b1) begin end_cyc = cyc; last_be = upper_be; end
      if (exp_beats.size() == 0) begin
        checks++;  errors++;
        $display("FAIL unexpected_beat got=%h want=none", upper_data);
      end else begin
        b = exp_beats.pop_front();
        chk("beat", 64'({upper_op_st, upper_op_end, upper_be, upper_data}),
            64'({b.st, b.en, b.be, b.d}));
      end
    end else begin
      chk("idle_out", 64'({upper_op_st, upper_op_end, upper_be, upper_data}), 64'(0));
    end
    if (drop_o === 1'b1) begin
      drop_cyc = cyc;
      drop_cause = int'(drop_cause_o);
      if (exp_drops.size() == 0) begin
        checks++;  errors++;
        $display("FAIL unexpected_drop got=%0d want=none", drop_cause_o);
      end else begin
        c = exp_drops.pop_front();
        chk("drop_cause", 64'(drop_cause_o), 64'(c));
      end
    end
  endtask

  task automatic clk_step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rcv_op_i = 1'b0;  rcv_op_st_i = 1'b0;  rcv_op_end_i = 1'b0;  rcv_data_i = 32'hDEAD_BEEF;
  endtask

  task automatic drive_word(input logic [47:0] mac, input logic [15:0] et, input int i, input int n);
    rcv_op_i = 1'b1;  rcv_op_st_i = (i == 0);  rcv_op_end_i = (i == n - 1);
    rcv_data_i = fr[i];  dest_addr_i = mac;  prot_type_i = et;
    w_cyc[i] = cyc + 1;
    clk_step();
  endtask

  task automatic clear_obs();
    nbeats = 0;  drop_cyc = -1;  drop_cause = -1;  st_cyc = -1;  end_cyc = -1;
    first_d = '0;  last_be = '0;
  endtask

  task automatic send(input logic [47:0] mac, input logic [15:0] et, input int n, input int gap_at);
    model(mac, et, n);
    clear_obs();
    for (int i = 0; i < n; i++) begin
      drive_word(mac, et, i, n);
      if (i == gap_at) begin idle_in(); clk_step(); end
    end
    idle_in();
    repeat (3) clk_step();
    chk("beats_left", 64'(exp_beats.size()), 64'(0));
    chk("drops_left", 64'(exp_drops.size()), 64'(0));
    exp_beats.delete();
    exp_drops.delete();
  endtask

  initial begin
    rst = 1'b1;  idle_in();  dest_addr_i = '0;  prot_type_i = '0;
    @(posedge clk);  #1;
    repeat (2) clk_step();
    rst = 1'b0;
    chk("rst_upper", 64'({upper_op_st, upper_op, upper_op_end, upper_be, upper_data}), 64'(0));
    chk("rst_drop", 64'({drop_o, drop_cause_o}), 64'(0));
    chk("rst_meta", 64'({upper_data_len, prot_type_o, pseudo_crc_sum_o}), 64'(0));
    cmp_en = 1'b1;

    // good UDP datagram, 13 payload bytes
    build(5, 33, 1'b0, 0, IP0, 1'b0);  send(DEV_MAC, 16'h0800, 9, -1);
    chk("s1_nbeats", 64'(nbeats), 64'(4));
    chk("s1_first", 64'(first_d), 64'(32'hC0DE_0005));
    chk("s1_last_be", 64'(last_be), 64'(4'b1000));
    chk("s1_len", 64'(upper_data_len), 64'(13));
    chk("s1_st_lat", 64'(st_cyc), 64'(w_cyc[5] + 1));
    chk("s1_no_drop", 64'(drop_cyc), 64'(-1));

    // one header bit flipped
    build(5, 33, 1'b0, 0, IP0, 1'b1);  send(DEV_MAC, 16'h0800, 9, -1);
    chk("s2_nbeats", 64'(nbeats), 64'(0));
    chk("s2_cause", 64'(drop_cause), 64'(4));
    chk("s2_drop_t", 64'(drop_cyc), 64'(w_cyc[4] + 1));

    // IHL=7 with options, second local IP, an idle gap inside the header
    build(7, 40, 1'b0, 0, IP1, 1'b0);  send(DEV_MAC, 16'h0800, 10, 3);
    chk("s3_nbeats", 64'(nbeats), 64'(3));
    chk("s3_first", 64'(first_d), 64'(32'hC0DE_0007));
    chk("s3_last_be", 64'(last_be), 64'(4'b1111));
    chk("s3_dst", 64'(dest_addr_o), 64'(IP1));

    // 60-byte frame carrying 28-byte datagram: padding stripped
    build(5, 28, 1'b0, 0, IP0, 1'b0);  send(DEV_MAC, 16'h0800, 15, -1);
    chk("s4_nbeats", 64'(nbeats), 64'(2));
    chk("s4_end_t", 64'(end_cyc), 64'(w_cyc[6] + 1));
    chk("s4_no_drop", 64'(drop_cyc), 64'(-1));

    build(5, 33, 1'b1, 0, IP0, 1'b0);  send(DEV_MAC, 16'h0800, 9, -1);
    chk("s5_mf_cause", 64'(drop_cause), 64'(6));
    build(5, 33, 1'b0, 100, IP0, 1'b0);  send(DEV_MAC, 16'h0800, 9, -1);
    chk("s5_off_cause", 64'(drop_cause), 64'(6));

    build(5, 33, 1'b0, 0, IP0, 1'b0);  send(DEV_MAC ^ 48'h1, 16'h0800, 9, -1);
    chk("s6_mac_cause", 64'(drop_cause), 64'(1));
    chk("s6_drop_t", 64'(drop_cyc), 64'(w_cyc[0] + 1));

    build(5, 33, 1'b0, 0, IP0, 1'b0);  send(DEV_MAC, 16'h86DD, 9, -1);
    chk("s7_et_cause", 64'(drop_cause), 64'(2));

    build(5, 33, 1'b0, 0, IP0, 1'b0);  fr[0][31:28] = 4'h6;  send(DEV_MAC, 16'h0800, 9, -1);
    chk("s8_ver_cause", 64'(drop_cause), 64'(3));

    build(5, 33, 1'b0, 0, 32'hC0A8_010C, 1'b0);  send(DEV_MAC, 16'h0800, 9, -1);
    chk("s9_ip_cause", 64'(drop_cause), 64'(5));

    // broadcast MAC + broadcast IP, exactly one full payload word
    build(5, 24, 1'b0, 0, 32'hFFFF_FFFF, 1'b0);  send(48'hFFFF_FFFF_FFFF, 16'h0800, 6, -1);
    chk("s10_nbeats", 64'(nbeats), 64'(1));
    chk("s10_be", 64'(last_be), 64'(4'b1111));

    build(5, 16, 1'b0, 0, IP0, 1'b0);  send(DEV_MAC, 16'h0800, 9, -1);
    chk("s11_len_cause", 64'(drop_cause), 64'(7));

    // frame ends before total_len bytes
    build(5, 60, 1'b0, 0, IP0, 1'b0);  send(DEV_MAC, 16'h0800, 8, -1);
    chk("s12_nbeats", 64'(nbeats), 64'(3));
    chk("s12_cause", 64'(drop_cause), 64'(7));
    chk("s12_same_t", 64'(drop_cyc), 64'(end_cyc));

    // header-only datagram inside a padded frame
    build(5, 20, 1'b0, 0, IP0, 1'b0);  send(DEV_MAC, 16'h0800, 15, -1);
    chk("s13_nbeats", 64'(nbeats), 64'(0));
    chk("s13_no_drop", 64'(drop_cyc), 64'(-1));

    // reset in the middle of the payload
    build(5, 33, 1'b0, 0, IP0, 1'b0);
    model(DEV_MAC, 16'h0800, 9);
    clear_obs();
    for (int i = 0; i < 7; i++) drive_word(DEV_MAC, 16'h0800, i, 9);
    idle_in();  rst = 1'b1;
    clk_step();
    rst = 1'b0;
    chk("s14_rst_upper", 64'({upper_op_st, upper_op, upper_op_end, upper_be, upper_data}), 64'(0));
    chk("s14_rst_meta", 64'({upper_data_len, prot_type_o, pseudo_crc_sum_o, drop_o, drop_cause_o}), 64'(0));
    chk("s14_rst_addr", 64'({source_addr_o, dest_addr_o}), 64'(0));
    exp_beats.delete();
    exp_drops.delete();
    clk_step();
    build(5, 33, 1'b0, 0, IP0, 1'b0);  send(DEV_MAC, 16'h0800, 9, -1);
    chk("s14_nbeats", 64'(nbeats), 64'(4));
    chk("s14_first", 64'(first_d), 64'(32'hC0DE_0005));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
